// File: rtl/load_store_unit.sv
// load_store_unit: sized/extended loads and stores with byte enables, valid/ack memory handshake,
// misalignment/illegal-funct3/timeout detection and a registered one-cycle response.
module load_store_unit #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           funct3,
    input  logic [A_WIDTH-1:0]   addr,
    input  logic [D_WIDTH-1:0]   wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [D_WIDTH-1:0]   rdata,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [A_WIDTH-1:0]   mem_addr,
    output logic [D_WIDTH-1:0]   mem_wdata,
    output logic [D_WIDTH/8-1:0] mem_be,
    input  logic                 mem_ack,
    input  logic [D_WIDTH-1:0]   mem_rdata
);
    localparam int BW = D_WIDTH / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic                 r_mem_req, r_mem_we, r_err;
    logic [A_WIDTH-1:0]   r_mem_addr;
    logic [D_WIDTH-1:0]   r_mem_wdata, r_rdata;
    logic [BW-1:0]        r_mem_be;
    logic [2:0]           r_f3;
    logic [OW-1:0]        r_off;

    logic [OW-1:0]        w_off, w_amask;
    logic                 w_legal, w_aligned, w_accept, w_ok, w_timeout;
    logic [BW-1:0]        w_be;
    logic [D_WIDTH-1:0]   w_wsh, w_lane, w_shl, w_ext;
    logic signed [D_WIDTH-1:0] w_sx;
    logic [6:0]           w_sh;

    always_comb begin
        w_off     = addr[OW-1:0];
        w_legal   = !(req_we && funct3[2]) &&
                    ((funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                     (D_WIDTH == 64 && (funct3 inside {3'b011, 3'b110})));
        w_amask   = OW'((4'd1 << funct3[1:0]) - 4'd1);
        w_aligned = (w_off & w_amask) == '0;
        w_be      = BW'(8'hFF >> (4'd8 - (4'd1 << funct3[1:0]))) << w_off;
        w_wsh     = wdata << {w_off, 3'b000};
        w_accept  = req_valid && r_state == S_IDLE;
        w_ok      = w_legal && w_aligned;
        w_timeout = r_state == S_ACCESS && !mem_ack && r_cnt == CW'(TIMEOUT - 1);
    end

    // Extension by shifting the selected lane to the top and back down.
    always_comb begin
        w_lane = mem_rdata >> {r_off, 3'b000};
        w_sh   = 7'(D_WIDTH) - (7'd8 << r_f3[1:0]);
        w_shl  = w_lane << w_sh;
        w_sx   = $signed(w_shl) >>> w_sh;
        w_ext  = r_f3[2] ? (w_shl >> w_sh) : w_sx;
    end

    always_comb begin
        w_next = (r_state == S_IDLE)   ? (w_accept ? (w_ok ? S_ACCESS : S_RESP) : S_IDLE) :
                 (r_state == S_ACCESS) ? ((mem_ack || w_timeout) ? S_RESP : S_ACCESS) :
                                         S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_f3        <= '0;
            r_off       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rdata <= (r_state == S_ACCESS && mem_ack && !r_mem_we) ? w_ext : '0;
            r_err   <= (w_accept && !w_ok) || w_timeout;
            if (w_accept && w_ok) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= req_we;
                r_mem_addr  <= addr & ~A_WIDTH'(BW - 1);
                r_mem_wdata <= w_wsh;
                r_mem_be    <= w_be;
                r_f3        <= funct3;
                r_off       <= w_off;
                r_cnt       <= '0;
            end else if (r_state == S_ACCESS) begin
                if (mem_ack || w_timeout) begin
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_be    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign req_ready = r_state == S_IDLE;
    assign busy      = r_state != S_IDLE;
    assign rsp_valid = r_state == S_RESP;
    assign rsp_err   = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
endmodule
